// File: rtl/mult_div_unit_if.sv
// Issue/result bundle between the pipeline and the multiply/divide unit.
// The pipeline is the master; the unit is the slave.
interface mult_div_unit_if;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] HI_in;
  logic [31:0] LO_in;
  logic [31:0] HI_output;
  logic [31:0] LO_output;
  logic        regWrite;
  logic        Busy;

  modport master (
    output Start, Op, A, B, HI_in, LO_in,
    input  HI_output, LO_output, regWrite, Busy
  );

  modport slave (
    input  Start, Op, A, B, HI_in, LO_in,
    output HI_output, LO_output, regWrite, Busy
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU/MADD/MSUB unit feeding HI/LO.
// Fixed 34-cycle latency: 32 shift-add / restoring steps, one sign-fix cycle, one write cycle.
module mult_div_unit (
  input  logic             Clk,
  input  logic             Reset,
  mult_div_unit_if.slave   bus
);
  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MADD  = 3'd4;
  localparam logic [2:0] OP_MSUB  = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t          r_state;
  logic [2:0]      r_op;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_hi_in;
  logic [W-1:0]    r_lo_in;
  logic [W-1:0]    r_dv;
  logic [2*W-1:0]  r_prod;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_hi;
  logic [W-1:0]    r_lo;
  logic            r_wr;
  logic            r_busy;

  // Issue-side decode, taken straight from the bus while idle
  logic            w_legal;
  logic            w_in_signed;
  logic            w_in_div;
  logic [W-1:0]    w_a_mag;
  logic [W-1:0]    w_b_mag;

  assign w_legal     = (bus.Op <= OP_MSUB);
  assign w_in_signed = (bus.Op != OP_MULTU) && (bus.Op != OP_DIVU);
  assign w_in_div    = (bus.Op == OP_DIV) || (bus.Op == OP_DIVU);
  assign w_a_mag     = (w_in_signed && bus.A[W-1]) ? W'(-bus.A) : bus.A;
  assign w_b_mag     = (w_in_signed && bus.B[W-1]) ? W'(-bus.B) : bus.B;

  // Latched-op decode used during RUN/FIX
  logic            w_signed;
  logic            w_div;
  logic            w_sgn_diff;

  assign w_signed   = (r_op != OP_MULTU) && (r_op != OP_DIVU);
  assign w_div      = (r_op == OP_DIV) || (r_op == OP_DIVU);
  assign w_sgn_diff = w_signed && (r_a[W-1] ^ r_b[W-1]);

  // Multiply step: conditionally add multiplicand to upper half, shift right
  logic [W:0]      w_sum;
  logic [2*W-1:0]  w_mul_nxt;

  assign w_sum     = {1'b0, r_prod[2*W-1:W]} + (r_prod[0] ? {1'b0, r_dv} : (W+1)'(0));
  assign w_mul_nxt = {w_sum, r_prod[W-1:1]};

  // Restoring divide step: remainder in upper half, quotient shifts into lower half
  logic            w_ge;
  logic [W-1:0]    w_diff;
  logic [2*W-1:0]  w_div_nxt;

  assign w_ge      = (r_prod[2*W-1:W-1] >= {1'b0, r_dv});
  assign w_diff    = W'(r_prod[2*W-2:W-1] - r_dv);
  assign w_div_nxt = w_ge ? {w_diff, r_prod[W-2:0], 1'b1} : {r_prod[2*W-2:0], 1'b0};

  // Sign correction and accumulate, applied in FIX
  logic [2*W-1:0]  w_prod_s;
  logic [W-1:0]    w_quo;
  logic [W-1:0]    w_rem;
  logic [2*W-1:0]  w_fix;

  assign w_prod_s = w_sgn_diff ? (2*W)'(-r_prod) : r_prod;
  assign w_quo    = w_sgn_diff ? W'(-r_prod[W-1:0]) : r_prod[W-1:0];
  assign w_rem    = (w_signed && r_a[W-1]) ? W'(-r_prod[2*W-1:W]) : r_prod[2*W-1:W];

  always_comb begin
    w_fix = w_prod_s;
    if (w_div) begin
      w_fix = (r_b == '0) ? {r_a, {W{1'b1}}} : {w_rem, w_quo};
    end else if (r_op == OP_MADD) begin
      w_fix = (2*W)'({r_hi_in, r_lo_in} + w_prod_s);
    end else if (r_op == OP_MSUB) begin
      w_fix = (2*W)'({r_hi_in, r_lo_in} - w_prod_s);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_hi_in <= '0;
      r_lo_in <= '0;
      r_dv    <= '0;
      r_prod  <= '0;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_wr    <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_wr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.Start && w_legal) begin
            r_op    <= bus.Op;
            r_a     <= bus.A;
            r_b     <= bus.B;
            r_hi_in <= bus.HI_in;
            r_lo_in <= bus.LO_in;
            r_dv    <= w_in_div ? w_b_mag : w_a_mag;
            r_prod  <= {{W{1'b0}}, (w_in_div ? w_a_mag : w_b_mag)};
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_prod <= w_div ? w_div_nxt : w_mul_nxt;
          r_cnt  <= CW'(r_cnt + 1'b1);
          if (r_cnt == CW'(W - 1)) r_state <= S_FIX;
        end
        S_FIX: begin
          r_prod  <= w_fix;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_hi    <= r_prod[2*W-1:W];
          r_lo    <= r_prod[W-1:0];
          r_wr    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.HI_output = r_hi;
  assign bus.LO_output = r_lo;
  assign bus.regWrite  = r_wr;
  assign bus.Busy      = r_busy;
endmodule
